// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor, gate level.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bin;
  assign bo      = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, valid/ready on both sides.
// Optional signed overflow flag is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             cell_d;
  logic             cell_bo;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  full_sub_cell u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (bout),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // State register; handshake/status flags are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == S_IDLE);
      out_valid <= (state_next == S_DONE);
      busy      <= (state_next == S_SHIFT) || (state_next == S_DONE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid)  state_next = S_SHIFT;
      S_SHIFT: if (last)      state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  // Datapath: diff doubles as the result shift register, bout as the running borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      diff <= '0;
      bout <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sr <= a;
            b_sr <= b;
            bout <= bin;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          diff <= {cell_d, diff[WIDTH-1:1]};
          bout <= cell_bo;
          cnt  <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  // Overflow is resolved on the final shift, when the result MSB is produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ovf <= 1'b0;
          if (in_valid) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        S_SHIFT: begin
          if (last) ovf <= (a_msb != b_msb) && (cell_d != a_msb);
        end
        S_DONE: begin
          if (out_ready) ovf <= 1'b0;
        end
        default: ovf <= 1'b0;
      endcase
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an integer reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;

  int tests;
  int failed;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer subtraction; borrow is a negative result.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                       output logic [W-1:0] md, output logic mbo, output logic movf);
    int r;
    r    = int'(ma) - int'(mb) - int'(mbin);
    md   = W'(r & 255);
    mbo  = (r < 0);
`ifdef SERIAL_SUB_OVF_EN
    movf = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
`else
    movf = 1'b0;
`endif
  endtask

  // One full operation: accept, measure latency, hold for 'stall' cycles, consume.
  task automatic op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_bin,
                    input int stall);
    logic [W-1:0] ed;
    logic         ebo;
    logic         eovf;
    int           guard;
    int           lat;
    model(op_a, op_b, op_bin, ed, ebo, eovf);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    bin      = op_bin;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    lat      = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(W));
    check("diff", 32'(diff), 32'(ed));
    check("bout", 32'(bout), 32'(ebo));
    check("ovf", 32'(ovf), 32'(eovf));
    check("busy_done", 32'(busy), 32'd1);
    for (int i = 0; i < stall; i++) begin
      in_valid = ~in_valid;
      a        = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_diff", 32'(diff), 32'(ed));
      check("hold_bout", 32'(bout), 32'(ebo));
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = (stall > 0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("consumed", 32'(out_valid), 32'd0);
    check("no_same_cycle_load", 32'(busy), 32'd0);
    in_valid  = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    tests     = 0;
    failed    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op(8'h05, 8'h03, 1'b0, 0);
    op(8'h03, 8'h05, 1'b0, 0);
    op(8'h00, 8'h00, 1'b1, 0);
    op(8'h80, 8'h01, 1'b0, 0);
    op(8'h7F, 8'hFF, 1'b0, 1);
    op(8'hFF, 8'hFF, 1'b1, 0);
    op(8'h12, 8'h34, 1'b1, 5);

    // Reset after three bits have been shifted.
    in_valid = 1'b1;
    a        = 8'h55;
    b        = 8'h2A;
    bin      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(8'hA0, 8'h0F, 1'b0, 0);

    for (int i = 0; i < 1500; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
